// File: rtl/mm_access_pkg.sv
// Shared definitions for the memory-access stage: access sizes, FSM states and
// store-side lane helpers.
package mm_access_pkg;

    localparam logic [1:0] ACCESS_SZ_BYTE = 2'b00;
    localparam logic [1:0] ACCESS_SZ_HALF = 2'b01;
    localparam logic [1:0] ACCESS_SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        MMS_IDLE = 2'd0,
        MMS_REQ  = 2'd1,
        MMS_WAIT = 2'd2,
        MMS_DONE = 2'd3
    } mms_e;

    // The unused 2'b11 encoding behaves as a word access everywhere downstream.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? ACCESS_SZ_WORD : sz;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] strb;
        case (sz)
            ACCESS_SZ_BYTE: strb = 4'b0001 << lo;
            ACCESS_SZ_HALF: strb = 4'b0011 << {lo[1], 1'b0};
            default:        strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] wdata);
        logic [31:0] data;
        case (sz)
            ACCESS_SZ_BYTE: data = {4{wdata[7:0]}};
            ACCESS_SZ_HALF: data = {2{wdata[15:0]}};
            default:        data = wdata;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/mm_load_align.sv
// Combinational load-data alignment: picks the addressed byte/half lane out of
// the bus word and sign- or zero-extends it to 32 bits.
module mm_load_align
    import mm_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        fill;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        fill = 1'b0;
        case (size)
            ACCESS_SZ_BYTE: begin
                fill  = ~zero_ext & byte_lane[7];
                value = {{24{fill}}, byte_lane};
            end
            ACCESS_SZ_HALF: begin
                fill  = ~zero_ext & half_lane[15];
                value = {{16{fill}}, half_lane};
            end
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mm_access.sv
// Memory-access stage controller: one instruction in flight, drives the
// req/addr_ok/data_ok data bus and hands the extended load result to writeback.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// MMS_IDLE  | ready for a new instruction from EX
// MMS_REQ   | data_req asserted, waiting for addr_ok
// MMS_WAIT  | address accepted, waiting for data_ok (cancel set on flush)
// MMS_DONE  | out_valid asserted, waiting for out_ready
module mm_access
    import mm_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mm_re,
    input  logic        mm_we,
    input  logic        mm_load_unsigned,
    input  logic [1:0]  mm_access_sz,
    input  logic [31:0] mm_addr,
    input  logic [31:0] mm_wdata,
    input  logic        ex_ale,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    mms_e        state;
    logic        cancel;
    logic        ld_unsigned;
    logic        is_load;
    logic [31:0] load_value;
    logic [31:0] result;

    mm_load_align u_load_align (
        .rdata    (data_rdata),
        .addr_lo  (data_addr[1:0]),
        .size     (data_size),
        .zero_ext (ld_unsigned),
        .value    (load_value)
    );

    assign result = is_load ? load_value : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MMS_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_rdata   <= 32'd0;
            data_req    <= 1'b0;
            data_wr     <= 1'b0;
            data_size   <= 2'd0;
            data_wstrb  <= 4'd0;
            data_addr   <= 32'd0;
            data_wdata  <= 32'd0;
            cancel      <= 1'b0;
            ld_unsigned <= 1'b0;
            is_load     <= 1'b0;
        end else begin
            case (state)
                MMS_IDLE: begin
                    if (in_valid) begin
                        data_addr   <= mm_addr;
                        data_size   <= norm_size(mm_access_sz);
                        data_wr     <= mm_we;
                        data_wstrb  <= mm_we ? store_strobe(norm_size(mm_access_sz), mm_addr[1:0]) : 4'd0;
                        data_wdata  <= store_data(norm_size(mm_access_sz), mm_wdata);
                        ld_unsigned <= mm_load_unsigned;
                        is_load     <= mm_re & ~mm_we;
                        out_rdata   <= 32'd0;
                        cancel      <= 1'b0;
                        if (flush) begin
                            state <= MMS_IDLE;
                        end else if ((mm_re | mm_we) && !ex_ale) begin
                            state    <= MMS_REQ;
                            data_req <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            state     <= MMS_DONE;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end

                MMS_REQ: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (data_data_ok) begin
                            if (flush) begin
                                state    <= MMS_IDLE;
                                in_ready <= 1'b1;
                            end else begin
                                state     <= MMS_DONE;
                                out_valid <= 1'b1;
                                out_rdata <= result;
                            end
                        end else begin
                            // Accepted in the same cycle as a flush: the response
                            // still has to be drained before going idle.
                            state  <= MMS_WAIT;
                            cancel <= flush;
                        end
                    end else if (flush) begin
                        state    <= MMS_IDLE;
                        data_req <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end

                MMS_WAIT: begin
                    if (data_data_ok) begin
                        cancel <= 1'b0;
                        if (cancel || flush) begin
                            state    <= MMS_IDLE;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= MMS_DONE;
                            out_valid <= 1'b1;
                            out_rdata <= result;
                        end
                    end else if (flush) begin
                        cancel <= 1'b1;
                    end
                end

                MMS_DONE: begin
                    if (flush || out_ready) begin
                        state     <= MMS_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state    <= MMS_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_access.sv
// Self-checking bench for mm_access: directed scenarios plus randomized
// transactions, with expected writeback data queued at issue time.
module tb_mm_access;
    import mm_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        mm_re;
    logic        mm_we;
    logic        mm_load_unsigned;
    logic [1:0]  mm_access_sz;
    logic [31:0] mm_addr;
    logic [31:0] mm_wdata;
    logic        ex_ale;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mm_access dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .mm_re            (mm_re),
        .mm_we            (mm_we),
        .mm_load_unsigned (mm_load_unsigned),
        .mm_access_sz     (mm_access_sz),
        .mm_addr          (mm_addr),
        .mm_wdata         (mm_wdata),
        .ex_ale           (ex_ale),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_rdata        (out_rdata),
        .data_req         (data_req),
        .data_wr          (data_wr),
        .data_size        (data_size),
        .data_wstrb       (data_wstrb),
        .data_addr        (data_addr),
        .data_wdata       (data_wdata),
        .data_addr_ok     (data_addr_ok),
        .data_data_ok     (data_data_ok),
        .data_rdata       (data_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [1:0] sz, input logic u);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (rd >> (int'(a[1:0]) * 8)) & 32'h0000_00FF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (rd >> (int'(a[1]) * 16)) & 32'h0000_FFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] s;
        if (sz == 2'b00) begin
            case (a[1:0])
                2'd0:    s = 4'b0001;
                2'd1:    s = 4'b0010;
                2'd2:    s = 4'b0100;
                default: s = 4'b1000;
            endcase
        end else if (sz == 2'b01) begin
            s = a[1] ? 4'b1100 : 4'b0011;
        end else begin
            s = 4'b1111;
        end
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'b00) return {w[7:0], w[7:0], w[7:0], w[7:0]};
        if (sz == 2'b01) return {w[15:0], w[15:0]};
        return w;
    endfunction

    task automatic idle_inputs();
        in_valid = 0; mm_re = 0; mm_we = 0; mm_load_unsigned = 0; mm_access_sz = 2'b00;
        mm_addr = 0; mm_wdata = 0; ex_ale = 0; flush = 0; out_ready = 1;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    endtask

    task automatic drive_accept(input logic re, input logic we, input logic u, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] w, input logic ale);
        in_valid = 1; mm_re = re; mm_we = we; mm_load_unsigned = u; mm_access_sz = sz;
        mm_addr = a; mm_wdata = w; ex_ale = ale;
        tick();
        in_valid = 0; mm_re = 0; mm_we = 0; ex_ale = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        checks++;
        if ({in_ready, out_valid, data_req, data_wr, data_size, data_wstrb} !== 10'b10_0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b",
                     {in_ready, out_valid, data_req, data_wr, data_size, data_wstrb}, 10'b10_0000_0000);
        end
        checks++;
        if ({data_addr, data_wdata, out_rdata} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h expected zeros", data_addr, data_wdata, out_rdata);
        end
    endtask

    task automatic test_load_byte();
        logic [31:0] got;
        exp_q.push_back(model_load(32'h80FF_FF00, 32'h0000_1003, ACCESS_SZ_BYTE, 1'b0));
        drive_accept(1, 0, 0, ACCESS_SZ_BYTE, 32'h0000_1003, 32'h0, 0);
        checks++;
        if ({data_req, data_wr, data_wstrb} !== 6'b10_0000 || data_addr !== 32'h0000_1003) begin
            errors++;
            $display("FAIL lb_req: got req=%b wr=%b strb=%b addr=%h expected 1 0 0000 00001003",
                     data_req, data_wr, data_wstrb, data_addr);
        end
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        checks++;
        if (data_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lb_wait: got req=%b valid=%b expected 0 0", data_req, out_valid);
        end
        data_data_ok = 1; data_rdata = 32'h80FF_FF00;
        tick();
        data_data_ok = 0;
        got = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_rdata !== got) begin
            errors++;
            $display("FAIL lb_result: got valid=%b data=%h expected 1 %h", out_valid, out_rdata, got);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lb_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_store_half();
        logic [31:0] got;
        exp_q.push_back(32'd0);
        drive_accept(0, 1, 0, ACCESS_SZ_HALF, 32'h0000_2002, 32'h0000_ABCD, 0);
        checks++;
        if (data_wstrb !== 4'b1100 || data_wdata !== 32'hABCD_ABCD || data_wr !== 1'b1 ||
            data_req !== 1'b1 || data_size !== ACCESS_SZ_HALF) begin
            errors++;
            $display("FAIL sh_req: got strb=%b wdata=%h wr=%b req=%b size=%b expected 1100 abcdabcd 1 1 01",
                     data_wstrb, data_wdata, data_wr, data_req, data_size);
        end
        data_addr_ok = 1; data_data_ok = 1;
        tick();
        data_addr_ok = 0; data_data_ok = 0;
        got = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_rdata !== got) begin
            errors++;
            $display("FAIL sh_result: got valid=%b data=%h expected 1 %h", out_valid, out_rdata, got);
        end
        tick();
    endtask

    task automatic test_addr_ok_stall();
        logic [31:0] got;
        exp_q.push_back(model_load(32'h1234_5678, 32'h3000_0004, ACCESS_SZ_WORD, 1'b0));
        drive_accept(1, 0, 0, ACCESS_SZ_WORD, 32'h3000_0004, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_req !== 1'b1 || data_addr !== 32'h3000_0004 || data_size !== ACCESS_SZ_WORD) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got req=%b addr=%h size=%b expected 1 30000004 10",
                         i, data_req, data_addr, data_size);
            end
            tick();
        end
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        checks++;
        if (data_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_wait: got req=%b valid=%b ready=%b expected 0 0 0", data_req, out_valid, in_ready);
        end
        tick();
        data_data_ok = 1; data_rdata = 32'h1234_5678;
        tick();
        data_data_ok = 0;
        got = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_rdata !== got) begin
            errors++;
            $display("FAIL stall_result: got valid=%b data=%h expected 1 %h", out_valid, out_rdata, got);
        end
        tick();
    endtask

    task automatic test_ale();
        logic [31:0] got;
        exp_q.push_back(32'd0);
        drive_accept(1, 0, 0, ACCESS_SZ_WORD, 32'h0000_4001, 32'h0, 1);
        got = exp_q.pop_front();
        checks++;
        if (data_req !== 1'b0 || out_valid !== 1'b1 || out_rdata !== got) begin
            errors++;
            $display("FAIL ale: got req=%b valid=%b data=%h expected 0 1 %h", data_req, out_valid, out_rdata, got);
        end
        tick();
    endtask

    task automatic test_flush_wait();
        drive_accept(1, 0, 0, ACCESS_SZ_WORD, 32'h0000_5000, 32'h0, 0);
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        flush = 1;
        tick();
        flush = 0;
        tick();
        data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
        tick();
        data_data_ok = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait: got valid=%b ready=%b req=%b expected 0 1 0", out_valid, in_ready, data_req);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_quiet: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_flush_req();
        drive_accept(0, 1, 0, ACCESS_SZ_BYTE, 32'h0000_6001, 32'h0000_0055, 0);
        tick();
        flush = 1;
        tick();
        flush = 0;
        checks++;
        if (data_req !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_req: got req=%b ready=%b valid=%b expected 0 1 0", data_req, in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] want;
        exp_q.push_back(model_load(32'hBEEF_1234, 32'h0000_7002, ACCESS_SZ_HALF, 1'b1));
        want = exp_q[0];
        out_ready = 0;
        drive_accept(1, 0, 1, ACCESS_SZ_HALF, 32'h0000_7002, 32'h0, 0);
        data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hBEEF_1234;
        tick();
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_rdata !== want || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b expected 1 %h 0",
                         i, out_valid, out_rdata, in_ready, want);
            end
            tick();
        end
        out_ready = 1;
        want = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_rdata !== want) begin
            errors++;
            $display("FAIL bp_final: got valid=%b data=%h expected 1 %h", out_valid, out_rdata, want);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_in_wait();
        drive_accept(0, 1, 0, ACCESS_SZ_WORD, 32'h0000_8004, 32'h1111_2222, 0);
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if ({in_ready, out_valid, data_req, data_wr, data_size, data_wstrb} !== 10'b10_0000_0000 ||
            {data_addr, data_wdata, out_rdata} !== 96'd0) begin
            errors++;
            $display("FAIL reset_wait: got ctrl=%b addr=%h wdata=%h rdata=%h expected 1000000000 zeros",
                     {in_ready, out_valid, data_req, data_wr, data_size, data_wstrb},
                     data_addr, data_wdata, out_rdata);
        end
    endtask

    task automatic run_txn(input logic re, input logic we, input logic u, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] w, input logic [31:0] rd,
                           input logic ale, input int aok_delay, input int dok_delay);
        logic [31:0] got;
        logic [1:0]  nsz;
        nsz = (sz == 2'b11) ? 2'b10 : sz;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL txn_ready: got %b expected 1", in_ready);
        end
        exp_q.push_back((re && !we && !ale) ? model_load(rd, a, nsz, u) : 32'd0);
        drive_accept(re, we, u, sz, a, w, ale);
        if ((re || we) && !ale) begin
            checks++;
            if (data_req !== 1'b1 || data_addr !== a || data_wr !== we || data_size !== nsz ||
                data_wstrb !== (we ? model_strb(nsz, a) : 4'd0) ||
                (we && data_wdata !== model_wdata(nsz, w))) begin
                errors++;
                $display("FAIL txn_req: got req=%b addr=%h wr=%b size=%b strb=%b wdata=%h for addr=%h sz=%b w=%h",
                         data_req, data_addr, data_wr, data_size, data_wstrb, data_wdata, a, sz, w);
            end
            repeat (aok_delay) tick();
            data_addr_ok = 1;
            if (dok_delay == 0) begin
                data_data_ok = 1; data_rdata = rd;
            end
            tick();
            data_addr_ok = 0; data_data_ok = 0;
            if (dok_delay > 0) begin
                repeat (dok_delay - 1) tick();
                data_data_ok = 1; data_rdata = rd;
                tick();
                data_data_ok = 0;
            end
        end
        got = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_rdata !== got) begin
            errors++;
            $display("FAIL txn_result: got valid=%b data=%h expected 1 %h (addr=%h sz=%b u=%b rd=%h)",
                     out_valid, out_rdata, got, a, sz, u, rd);
        end
        tick();
    endtask

    task automatic test_load_variants();
        run_txn(1, 0, 0, 2'b00, 32'h0000_0000, 0, 32'h1122_3344, 0, 0, 0);
        run_txn(1, 0, 0, 2'b00, 32'h0000_0001, 0, 32'h1122_B344, 0, 1, 0);
        run_txn(1, 0, 1, 2'b00, 32'h0000_0002, 0, 32'h11F2_3344, 0, 0, 1);
        run_txn(1, 0, 0, 2'b01, 32'h0000_0000, 0, 32'h1122_8344, 0, 0, 2);
        run_txn(1, 0, 0, 2'b01, 32'h0000_0002, 0, 32'h7122_8344, 0, 2, 1);
        run_txn(1, 0, 1, 2'b01, 32'h0000_0002, 0, 32'hF122_8344, 0, 0, 0);
        run_txn(1, 0, 0, 2'b11, 32'h0000_0008, 0, 32'h8765_4321, 0, 0, 0);
        run_txn(0, 1, 0, 2'b00, 32'h0000_0003, 32'h0000_00A5, 0, 0, 0, 1);
        run_txn(0, 1, 0, 2'b11, 32'h0000_0010, 32'hCAFE_F00D, 0, 0, 1, 0);
        run_txn(0, 0, 0, 2'b10, 32'h0000_0020, 0, 32'hFFFF_FFFF, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] rd;
        logic        u;
        int          op;
        for (int i = 0; i < 20; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom();
            w  = $urandom();
            rd = $urandom();
            u  = 1'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            run_txn(op == 0 || op == 3, op == 1, u, sz, a, w, rd, op == 3,
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_load_byte();
        test_store_half();
        test_addr_ok_stall();
        test_ale();
        test_flush_wait();
        test_flush_req();
        test_backpressure();
        test_reset_in_wait();
        test_load_variants();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
